alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Nibble-serial sequencer that runs 4·NIBBLES-bit operations through a single external 4-bit 74181-style ALU. It latches wide operands and the operation select, then presents one nibble per clock to the ALU, least significant first, rippling the carry between nibbles. It assembles the wide result, carry-out and A=B flag. It sits between the ui/uio pin mapping and the ALU instance in the top level.

## Interface

- NIBBLES, 4: number of 4-bit slices per operation; operand width W = 4·NIBBLES; legal range 2..8.
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
- start  input  1  request; sampled only in IDLE.
- op_a  input  W  operand A; latched on accepted start.
- op_b  input  W  operand B; latched on accepted start.
- op_s  input  4  ALU function select; latched on accepted start.
- op_m  input  1  mode (1 = logic, 0 = arithmetic); latched.
- op_cn  input  1  carry-in to nibble 0, 74181 polarity (1 = no carry); latched.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- done  output  1  one-cycle pulse; result, cout, equal valid from this cycle.
- result  output  W  assembled F; holds until the next DONE.
- cout  output  1  cn4 of the last nibble (74181 polarity).
- equal  output  1  AND of the ALU equal output over all nibbles.
- zero  output  1  result == 0 (see Configuration).
- alu_a, alu_b  output  4 each  current nibble to the ALU.
- alu_s  output  4  latched op_s.
- alu_m  output  1  latched op_m.
- alu_cn  output  1  carry into the current nibble.
- alu_f  input  4  ALU F.
- alu_cn4  input  1  ALU carry-out.
- alu_equal  input  1  ALU A=B output.

## Operation

- States: IDLE, RUN, DONE.
- IDLE, start=1: latch op_a/op_b/op_s/op_m/op_cn, set nib_idx=0, carry_reg=op_cn, eq_acc=1, then go to RUN. Start is ignored in RUN/DONE; there is no queuing.
- RUN, combinational ALU drive: alu_a/alu_b = latched operand bits [4·nib_idx+3 : 4·nib_idx], alu_cn = carry_reg, alu_s/alu_m = latched values.
- RUN, per cycle: capture alu_f into nibble nib_idx of the shadow buffer; carry_reg <= alu_cn4; eq_acc <= eq_acc & alu_equal; nib_idx++.
- RUN exit: after nib_idx = NIBBLES-1 is processed, go to DONE. The nibble counter never wraps past NIBBLES-1.
- DONE: result <= shadow buffer, cout <= carry_reg, equal <= eq_acc, done=1, then go to IDLE unconditionally. A start in the DONE cycle is ignored.
- Logic mode (m=1): carry still ripples, but the ALU ignores it, so cout is don't-care. Benches must not check it.
- In IDLE the alu_* outputs show nibble 0 of the latched operands. This is harmless.

## Timing

- Reset values: state IDLE, busy 0, done 0, result 0, cout 1, equal 0, zero 0. All internal registers are 0 except carry_reg=1.
- Start accepted at edge t: busy=1 after t. Nibble k is captured at edge t+1+k. DONE is entered after edge t+NIBBLES and done=1 during that cycle. busy drops after edge t+NIBBLES+1.
- Latency from start to done is NIBBLES+1 cycles; minimum start-to-start spacing is NIBBLES+2 cycles.
- Reset asserted mid-operation: return to IDLE immediately. The partial result is discarded, outputs take reset values, and no done pulse is issued.
- ALU path is purely combinational; alu_f is assumed to settle within one cycle.

## Configuration

- ALU_SEQ_ZERO_FLAG_EN defined: zero is registered in DONE as (shadow buffer == 0) and holds with result.
- ALU_SEQ_ZERO_FLAG_EN undefined: zero is tied to 0 and the comparator is not built. The port remains present.

## Structure

- Shared package alu_seq_pkg: state enum (IDLE/RUN/DONE), 74181 select constants (S_ADD=4'b1001, S_SUB=4'b0110 with M=0, S_XOR=4'b0110 with M=1), CN_NONE=1'b1.
- One natural sub-module: alu_seq_nibble_buf. It holds the W-bit shadow result register with a nibble-indexed write enable.
- The ALU itself is instantiated by the parent, not inside this block.

## Test plan

- Add, NIBBLES=4, S=1001 M=0 Cn=1, A=0x1234 B=0x0FFF -> done at t+5, result=0x2233, cout=1.
- Add with overflow, A=0xFFFF B=0x0001 -> result=0x0000, cout=0; zero=1 with macro, zero=0 without.
- Subtract-minus-one, S=0110 M=0 Cn=1, A=B=0x5A5A -> result=0xFFFF, equal=1. Repeat with B=0x5A5B -> equal=0.
- Logic XOR, S=0110 M=1, A=0xF0F0 B=0xFF00 -> result=0x0FF0. Also check that start pulses asserted while busy produce no extra done.
- Reset asserted at cycle t+2 of an operation -> busy=0, result=0 immediately, and no done pulse. A subsequent start completes normally.
- Back-to-back: start held high continuously -> accepted every NIBBLES+2 cycles, with exactly one done per accepted start.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and 74181 select constants for the nibble-serial ALU sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] S_ADD   = 4'b1001;  // with M=0
  localparam logic [3:0] S_SUB   = 4'b0110;  // A minus B minus 1, with M=0
  localparam logic [3:0] S_XOR   = 4'b0110;  // with M=1
  localparam logic       CN_NONE = 1'b1;

  function automatic int idx_width(input int nibbles);
    return (nibbles <= 2) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/alu_seq_nibble_buf.sv
// Shadow result register, written one 4-bit nibble at a time by index.
module alu_seq_nibble_buf
  import alu_seq_pkg::*;
#(
  parameter int NIBBLES = 4,
  localparam int W  = 4 * NIBBLES,
  localparam int IW = idx_width(NIBBLES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [IW-1:0] i_idx,
  input  logic [3:0]    i_nib,
  output logic [W-1:0]  o_buf
);

  logic [W-1:0] r_buf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf <= '0;
    end else if (i_we) begin
      r_buf[4*i_idx +: 4] <= i_nib;
    end
  end

  assign o_buf = r_buf;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Nibble-serial sequencer driving one external 74181-style ALU, LSB nibble first.
// Optional zero flag: define ALU_SEQ_ZERO_FLAG_EN to build the result==0 comparator.
//
// state   | meaning
// IDLE    | waiting for start; alu_* show nibble 0 of the latched operands
// RUN     | one nibble per cycle through the ALU, carry rippled in r_carry
// DONE    | result/cout/equal valid, done pulse, back to IDLE
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int NIBBLES = 4,
  localparam int W  = 4 * NIBBLES,
  localparam int IW = idx_width(NIBBLES)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_op_a,
  input  logic [W-1:0] i_op_b,
  input  logic [3:0]   i_op_s,
  input  logic         i_op_m,
  input  logic         i_op_cn,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_result,
  output logic         o_cout,
  output logic         o_equal,
  output logic         o_zero,
  output logic [3:0]   o_alu_a,
  output logic [3:0]   o_alu_b,
  output logic [3:0]   o_alu_s,
  output logic         o_alu_m,
  output logic         o_alu_cn,
  input  logic [3:0]   i_alu_f,
  input  logic         i_alu_cn4,
  input  logic         i_alu_equal
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_a, r_b;
  logic [3:0]    r_s;
  logic          r_m;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic          r_eq;
  logic [W-1:0]  r_result;
  logic          r_cout;
  logic          r_equal;

  logic          w_load, w_cap, w_last, w_busy, w_done;
  logic [W-1:0]  w_shadow;
  logic [W-1:0]  w_final;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_cap       = 1'b0;
    w_last      = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_busy = 1'b1;
        w_cap  = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_last      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  alu_seq_nibble_buf #(.NIBBLES(NIBBLES)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .i_we  (w_cap),
    .i_idx (r_idx),
    .i_nib (i_alu_f),
    .o_buf (w_shadow)
  );

  // Outputs are published on entry to DONE, so the last nibble is merged in directly.
  always_comb begin
    w_final                = w_shadow;
    w_final[4*r_idx +: 4]  = i_alu_f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_s      <= '0;
      r_m      <= 1'b0;
      r_idx    <= '0;
      r_carry  <= 1'b1;
      r_eq     <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b1;
      r_equal  <= 1'b0;
    end else begin
      if (w_load) begin
        r_a     <= i_op_a;
        r_b     <= i_op_b;
        r_s     <= i_op_s;
        r_m     <= i_op_m;
        r_idx   <= '0;
        r_carry <= i_op_cn;
        r_eq    <= 1'b1;
      end
      if (w_cap) begin
        r_carry <= i_alu_cn4;
        r_eq    <= r_eq & i_alu_equal;
        if (!w_last) r_idx <= r_idx + IW'(1);
      end
      if (w_last) begin
        r_result <= w_final;
        r_cout   <= i_alu_cn4;
        r_equal  <= r_eq & i_alu_equal;
      end
      if (w_done) r_idx <= '0;
    end
  end

`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic r_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_zero <= 1'b0;
    else if (w_last) r_zero <= (w_final == '0);
  end

  assign o_zero = r_zero;
`else
  assign o_zero = 1'b0;
`endif

  assign o_busy   = w_busy;
  assign o_done   = w_done;
  assign o_result = r_result;
  assign o_cout   = r_cout;
  assign o_equal  = r_equal;
  assign o_alu_a  = r_a[4*r_idx +: 4];
  assign o_alu_b  = r_b[4*r_idx +: 4];
  assign o_alu_s  = r_s;
  assign o_alu_m  = r_m;
  assign o_alu_cn = r_carry;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with a behavioural 74181 attached to the ALU port.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic         clk, rst_n, start;
  logic [W-1:0] op_a, op_b;
  logic [3:0]   op_s;
  logic         op_m, op_cn;
  logic         busy, done, cout, equal, zero;
  logic [W-1:0] result;
  logic [3:0]   alu_a, alu_b, alu_s, alu_f;
  logic         alu_m, alu_cn, alu_cn4, alu_equal;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  alu_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start),
    .i_op_a(op_a), .i_op_b(op_b), .i_op_s(op_s), .i_op_m(op_m), .i_op_cn(op_cn),
    .o_busy(busy), .o_done(done), .o_result(result), .o_cout(cout),
    .o_equal(equal), .o_zero(zero),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_s(alu_s), .o_alu_m(alu_m),
    .o_alu_cn(alu_cn), .i_alu_f(alu_f), .i_alu_cn4(alu_cn4), .i_alu_equal(alu_equal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 74181 function table at arbitrary width w; returns {cn_out, f}. cn is active-low carry.
  function automatic logic [32:0] alu_fn(input int w, input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] s, input logic m, input logic cn);
    logic [32:0] mask, aa, bb, na, nb, x, y, sum, f;
    logic co;
    mask = (33'd1 << w) - 33'd1;
    aa = {1'b0, a} & mask;
    bb = {1'b0, b} & mask;
    na = ~aa & mask;
    nb = ~bb & mask;
    x = '0; y = '0; f = '0; co = cn;
    if (m) begin
      case (s)
        4'd0:  f = na;
        4'd1:  f = ~(aa | bb);
        4'd2:  f = na & bb;
        4'd3:  f = '0;
        4'd4:  f = ~(aa & bb);
        4'd5:  f = nb;
        4'd6:  f = aa ^ bb;
        4'd7:  f = aa & nb;
        4'd8:  f = na | bb;
        4'd9:  f = ~(aa ^ bb);
        4'd10: f = bb;
        4'd11: f = aa & bb;
        4'd12: f = mask;
        4'd13: f = aa | nb;
        4'd14: f = aa | bb;
        default: f = aa;
      endcase
      f = f & mask;
    end else begin
      case (s)
        4'd0:  begin x = aa;        y = '0;        end
        4'd1:  begin x = aa | bb;   y = '0;        end
        4'd2:  begin x = aa | nb;   y = '0;        end
        4'd3:  begin x = mask;      y = '0;        end
        4'd4:  begin x = aa;        y = aa & nb;   end
        4'd5:  begin x = aa | bb;   y = aa & nb;   end
        4'd6:  begin x = aa;        y = nb;        end
        4'd7:  begin x = aa & nb;   y = mask;      end
        4'd8:  begin x = aa;        y = aa & bb;   end
        4'd9:  begin x = aa;        y = bb;        end
        4'd10: begin x = aa | nb;   y = aa & bb;   end
        4'd11: begin x = aa & bb;   y = mask;      end
        4'd12: begin x = aa;        y = aa;        end
        4'd13: begin x = aa | bb;   y = aa;        end
        4'd14: begin x = aa | nb;   y = aa;        end
        default: begin x = aa;      y = mask;      end
      endcase
      sum = x + y + (cn ? 33'd0 : 33'd1);
      f = sum & mask;
      co = ~sum[w];
    end
    return {co, f[31:0]};
  endfunction

  logic [32:0] w_alu;
  assign w_alu     = alu_fn(4, {28'b0, alu_a}, {28'b0, alu_b}, alu_s, alu_m, alu_cn);
  assign alu_f     = w_alu[3:0];
  assign alu_cn4   = w_alu[32];
  assign alu_equal = &w_alu[3:0];

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] s, input logic m, input logic cn,
                        input logic [W-1:0] er, input logic ec, input logic chk_c,
                        input logic eeq, input logic ez);
    int n;
    @(negedge clk);
    op_a = a; op_b = b; op_s = s; op_m = m; op_cn = cn; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); op_s = 4'($urandom); op_m = ~m; op_cn = ~cn;
    check({tag, "/busy_after_start"}, {31'b0, busy}, 32'd1);
    n = 0;
    while (!done && n < NIBBLES + 6) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check({tag, "/latency"}, n, NIBBLES);
    check({tag, "/result"}, {16'b0, result}, {16'b0, er});
    check({tag, "/equal"}, {31'b0, equal}, {31'b0, eeq});
    check({tag, "/zero"}, {31'b0, zero}, {31'b0, ez});
    if (chk_c) check({tag, "/cout"}, {31'b0, cout}, {31'b0, ec});
    @(negedge clk);
    check({tag, "/done_one_cycle"}, {31'b0, done}, 32'd0);
    check({tag, "/idle_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "/result_hold"}, {16'b0, result}, {16'b0, er});
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    logic [3:0]   s;
    logic         m, cn;
    logic [W-1:0] res;
    logic         cout, chk_cout, eq;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int base, dn;
    int dpos[8];
    logic [32:0] r;
    logic [W-1:0] ra, rb;
    logic [3:0] rs;
    logic rm, rc;

    vecs[0] = '{16'h1234, 16'h0FFF, S_ADD, 1'b0, CN_NONE, 16'h2233, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, S_ADD, 1'b0, CN_NONE, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'h5A5A, 16'h5A5A, S_SUB, 1'b0, CN_NONE, 16'hFFFF, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{16'h5A5A, 16'h5A5B, S_SUB, 1'b0, CN_NONE, 16'hFFFE, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{16'hF0F0, 16'hFF00, S_XOR, 1'b1, CN_NONE, 16'h0FF0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{16'h00FF, 16'h0000, S_ADD, 1'b0, 1'b0,    16'h0100, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{16'h1000, 16'h0001, S_SUB, 1'b0, 1'b0,    16'h0FFF, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; op_s = '0; op_m = 1'b0; op_cn = 1'b1;
    repeat (2) @(negedge clk);
    check("reset/busy", {31'b0, busy}, 32'd0);
    check("reset/done", {31'b0, done}, 32'd0);
    check("reset/result", {16'b0, result}, 32'd0);
    check("reset/cout", {31'b0, cout}, 32'd1);
    check("reset/equal", {31'b0, equal}, 32'd0);
    check("reset/zero", {31'b0, zero}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m, vecs[i].cn,
             vecs[i].res, vecs[i].cout, vecs[i].chk_cout, vecs[i].eq,
             ZF && (vecs[i].res == '0));

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom); rs = 4'($urandom_range(0, 15));
      rm = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      if (i % 8 == 0) rb = ra;
      r = alu_fn(W, {16'b0, ra}, {16'b0, rb}, rs, rm, rc);
      run_op($sformatf("rnd%0d", i), ra, rb, rs, rm, rc, r[W-1:0], r[32], !rm,
             &r[W-1:0], ZF && (r[W-1:0] == '0));
    end

    // Start held through RUN and DONE must yield exactly one operation.
    base = done_cnt;
    @(negedge clk);
    op_a = 16'hF0F0; op_b = 16'hFF00; op_s = S_XOR; op_m = 1'b1; op_cn = CN_NONE; start = 1'b1;
    repeat (NIBBLES + 2) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("busy_start/result", {16'b0, result}, 32'h0FF0);
    check("busy_start/idle", {31'b0, busy}, 32'd0);
    repeat (NIBBLES + 3) @(negedge clk);
    check("busy_start/done_count", done_cnt - base, 1);

    // Reset two cycles into an operation.
    @(negedge clk);
    op_a = 16'h1111; op_b = 16'h2222; op_s = S_ADD; op_m = 1'b0; op_cn = CN_NONE; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    base = done_cnt;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset/busy", {31'b0, busy}, 32'd0);
    check("midreset/done", {31'b0, done}, 32'd0);
    check("midreset/result", {16'b0, result}, 32'd0);
    check("midreset/cout", {31'b0, cout}, 32'd1);
    check("midreset/equal", {31'b0, equal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (NIBBLES + 4) @(negedge clk);
    check("midreset/no_done", done_cnt - base, 0);
    run_op("after_reset", 16'h1111, 16'h2222, S_ADD, 1'b0, CN_NONE, 16'h3333, 1'b1, 1'b1,
           1'b0, 1'b0);

    // Back-to-back with start held high: one accept every NIBBLES+2 cycles.
    for (int i = 0; i < 8; i++) dpos[i] = -1;
    dn = 0;
    base = done_cnt;
    @(negedge clk);
    op_a = 16'h0101; op_b = 16'h0202; op_s = S_ADD; op_m = 1'b0; op_cn = CN_NONE; start = 1'b1;
    for (int e = 0; e < 3 * (NIBBLES + 2); e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        if (dn < 8) dpos[dn] = e;
        dn++;
      end
    end
    start = 1'b0;
    check("b2b/done_count", dn, 3);
    check("b2b/done0_pos", dpos[0], NIBBLES);
    check("b2b/done1_pos", dpos[1], 2 * NIBBLES + 2);
    check("b2b/done2_pos", dpos[2], 3 * NIBBLES + 4);
    check("b2b/result", {16'b0, result}, 32'h0303);
    repeat (NIBBLES + 3) @(negedge clk);
    check("b2b/total_done", done_cnt - base, 3);
    check("b2b/idle", {31'b0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
